// File: rtl/booth_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_scheduler
// Purpose  : Round-robin, credit-gated issue of requester operand pairs to a
//            shared pipelined multiplier; tagged products land in an FWFT FIFO.
//            Define BOOTH_SCHED_PERF_EN to add perf_issue/perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_scheduler #(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       a_in,
  input  logic [N_REQ*W-1:0]       b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     mul_vld,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_p,
  output logic                     res_vld,
  input  logic                     res_ready,
  output logic [2*W-1:0]           res_p,
  output logic [$clog2(N_REQ)-1:0] res_id
`ifdef BOOTH_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_stall
`endif
);

  localparam int c_idw = $clog2(N_REQ);
  localparam int c_pw  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw  = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_idw-1:0] c_last_id  = c_idw'(N_REQ - 1);
  localparam logic [c_pw-1:0]  c_last_ptr = c_pw'(FIFO_DEPTH - 1);
  localparam logic [c_cw-1:0]  c_depth    = c_cw'(FIFO_DEPTH);

  logic [W-1:0]       w_a [N_REQ];
  logic [W-1:0]       w_b [N_REQ];
  logic [c_idw-1:0]   r_rr_ptr;
  logic [c_idw-1:0]   w_idx;
  logic [c_idw-1:0]   w_sel;
  logic               w_any;
  logic               w_credit_ok;
  logic               w_grant;
  logic               w_push;
  logic               w_pop;
  logic [c_cw-1:0]    r_outstanding;
  logic [c_cw-1:0]    r_count;
  logic [c_pw-1:0]    r_wr_ptr;
  logic [c_pw-1:0]    r_rd_ptr;
  logic               r_tag_vld [LAT+1];
  logic [c_idw-1:0]   r_tag_id  [LAT+1];
  logic [2*W-1:0]     r_mem_p   [FIFO_DEPTH];
  logic [c_idw-1:0]   r_mem_id  [FIFO_DEPTH];

  function automatic logic [c_pw-1:0] f_ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_a[i] = a_in[i*W +: W];
    assign w_b[i] = b_in[i*W +: W];
  end

  // Scan from rr_ptr; descending k so the nearest asserted request wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = c_idw'((int'(r_rr_ptr) + k) % N_REQ);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // A credit stays held from grant until the cycle after its result pops.
  assign w_credit_ok = (r_outstanding < c_depth);
  assign w_grant     = w_any & w_credit_ok & ~reset;
  assign gnt         = w_grant ? (N_REQ'(1) << w_sel) : '0;
  assign w_push      = r_tag_vld[LAT];
  assign w_pop       = res_vld & res_ready;
  assign res_vld     = (r_count != '0);
  assign res_p       = res_vld ? r_mem_p[r_rd_ptr]  : '0;
  assign res_id      = res_vld ? r_mem_id[r_rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      mul_vld  <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      mul_vld <= w_grant;
      if (w_grant) begin
        r_rr_ptr <= (w_sel == c_last_id) ? '0 : w_sel + 1'b1;
        mul_a    <= w_a[w_sel];
        mul_b    <= w_b[w_sel];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant;
      r_tag_id[0]  <= w_sel;
      for (int s = 1; s <= LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      case ({w_grant, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_p[r_wr_ptr]  <= mul_p;
      r_mem_id[r_wr_ptr] <= r_tag_id[LAT];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && (r_count == c_depth)))
        else $fatal(1, "booth_mul_scheduler: push into full result FIFO");
    end
  end
`endif

`ifdef BOOTH_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (w_grant && (perf_issue != '1))
        perf_issue <= perf_issue + 32'd1;
      if (w_any && !w_credit_ok && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
